// File: rtl/pacman_video_pkg.sv
// Shared video definitions for the pacman display path: item codes,
// the transparent palette index, the colour palette and pipeline sideband types.
package pacman_video_pkg;

   localparam logic [1:0] ITEM_NONE   = 2'd0;
   localparam logic [1:0] ITEM_DOT    = 2'd1;
   localparam logic [1:0] ITEM_PELLET = 2'd2;

   localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Per-pixel control that travels alongside the ROM reads.
   typedef struct packed {
      logic [1:0] sel;
      logic [1:0] item;
      logic       hsync;
      logic       vsync;
      logic       blank_n;
   } sideband_t;

   localparam sideband_t SIDEBAND_RESET = '{sel: 2'b00, item: ITEM_NONE,
                                            hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

   localparam logic [23:0] PALETTE [16] = '{
      24'h000000, 24'hFF0000, 24'hDEDEFF, 24'hFFB8AE,
      24'hFFB8FF, 24'h00FFFF, 24'h47B8FF, 24'hFFB851,
      24'hFFFF00, 24'h2121FF, 24'h00FF00, 24'h47B8AE,
      24'hFFB8DE, 24'hDE9751, 24'hFFFFFF, 24'h808080
   };

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register chain with a configurable reset value, used to keep
// timing and control bits aligned with the ROM read pipeline.
module sync_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
      end else begin
         stages[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign o_q = stages[DEPTH-1];

endmodule

// File: rtl/vga_pixel_compositor.sv
// Issues tile/item/sprite ROM reads, resolves layer priority and pellet blink,
// maps palette indices to RGB and keeps sync/blank aligned with the colour.
module vga_pixel_compositor
   import pacman_video_pkg::*;
#(
   parameter int LATENCY   = 3,
   parameter int BLINK_BIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_mem_select,
   input  logic [7:0]  i_address_map,
   input  logic [7:0]  i_address_char,
   input  logic [1:0]  i_address_item,
   input  logic [5:0]  i_tile_offset,
   input  logic [5:0]  i_char_offset,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_blank_n,
   input  logic        i_frame_start,
   input  logic        i_blink_en,
   output logic [13:0] o_tile_rom_addr,
   output logic [13:0] o_char_rom_addr,
   output logic [7:0]  o_item_rom_addr,
   input  logic [3:0]  i_tile_rom_data,
   input  logic [3:0]  i_char_rom_data,
   input  logic [3:0]  i_item_rom_data,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_blank_n
);

   sideband_t  sb_in;
   sideband_t  sb_s1;
   logic [5:0] frame_cnt;
   logic       pellet_visible;
   logic       item_shown;
   logic [3:0] pal_idx;
   rgb_t       pix_rgb;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_tile_rom_addr <= '0;
         o_char_rom_addr <= '0;
         o_item_rom_addr <= '0;
      end else begin
         o_tile_rom_addr <= {i_address_map, i_tile_offset};
         o_char_rom_addr <= {i_address_char, i_char_offset};
         o_item_rom_addr <= {i_address_item, i_tile_offset};
      end
   end

   assign sb_in = '{sel: i_mem_select, item: i_address_item,
                    hsync: i_hsync, vsync: i_vsync, blank_n: i_blank_n};

   // Two sideband stages line up with address register + ROM latency;
   // the output register below supplies the final stage.
   sync_delay_line #(
      .WIDTH    ($bits(sideband_t)),
      .DEPTH    (LATENCY - 1),
      .RESET_VAL(SIDEBAND_RESET)
   ) u_sideband (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_d    (sb_in),
      .o_q    (sb_s1)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)           frame_cnt <= '0;
      else if (i_frame_start) frame_cnt <= frame_cnt + 6'd1;
   end

   always_comb begin
      pal_idx        = TRANSPARENT_IDX;
      pellet_visible = (sb_s1.item != ITEM_PELLET) || !i_blink_en || !frame_cnt[BLINK_BIT];
      item_shown     = sb_s1.sel[0] && pellet_visible &&
                       ((sb_s1.item == ITEM_DOT) || (sb_s1.item == ITEM_PELLET)) &&
                       (i_item_rom_data != TRANSPARENT_IDX);
      // A transparent sprite pixel never falls through to the map layer unless sel[0] is set.
      if (sb_s1.sel[1] && (i_char_rom_data != TRANSPARENT_IDX)) pal_idx = i_char_rom_data;
      else if (item_shown)                                      pal_idx = i_item_rom_data;
      else if (sb_s1.sel[0])                                    pal_idx = i_tile_rom_data;
      pix_rgb = sb_s1.blank_n ? rgb_t'(PALETTE[pal_idx]) : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_r       <= '0;
         o_g       <= '0;
         o_b       <= '0;
         o_hsync   <= 1'b1;
         o_vsync   <= 1'b1;
         o_blank_n <= 1'b0;
      end else begin
         o_r       <= pix_rgb.r;
         o_g       <= pix_rgb.g;
         o_b       <= pix_rgb.b;
         o_hsync   <= sb_s1.hsync;
         o_vsync   <= sb_s1.vsync;
         o_blank_n <= sb_s1.blank_n;
      end
   end

endmodule

// File: tb/tb_vga_pixel_compositor.sv
// Directed bench for vga_pixel_compositor: synchronous ROM models, a
// sample-history reference model checked every cycle, and literal spot checks.
module tb_vga_pixel_compositor;

   localparam logic [23:0] PAL [16] = '{
      24'h000000, 24'hFF0000, 24'hDEDEFF, 24'hFFB8AE,
      24'hFFB8FF, 24'h00FFFF, 24'h47B8FF, 24'hFFB851,
      24'hFFFF00, 24'h2121FF, 24'h00FF00, 24'h47B8AE,
      24'hFFB8DE, 24'hDE9751, 24'hFFFFFF, 24'h808080
   };

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] map;
      logic [7:0] chr;
      logic [1:0] item;
      logic [5:0] toff;
      logic [5:0] coff;
      logic       hs;
      logic       vs;
      logic       bn;
   } pix_t;

   localparam pix_t RST_PIX = '{sel: 2'b00, map: 8'd0, chr: 8'd0, item: 2'd0,
                                toff: 6'd0, coff: 6'd0, hs: 1'b1, vs: 1'b1, bn: 1'b0};

   // ---------------- clock / reset / signals
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  i_mem_select = '0;
   logic [7:0]  i_address_map = '0;
   logic [7:0]  i_address_char = '0;
   logic [1:0]  i_address_item = '0;
   logic [5:0]  i_tile_offset = '0;
   logic [5:0]  i_char_offset = '0;
   logic        i_hsync = 1'b1;
   logic        i_vsync = 1'b1;
   logic        i_blank_n = 1'b0;
   logic        i_frame_start = 1'b0;
   logic        i_blink_en = 1'b1;
   logic [13:0] o_tile_rom_addr, o_char_rom_addr;
   logic [7:0]  o_item_rom_addr;
   logic [3:0]  tile_data, char_data, item_data;
   logic [7:0]  o_r, o_g, o_b;
   logic        o_hsync, o_vsync, o_blank_n;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   vga_pixel_compositor dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_mem_select   (i_mem_select),
      .i_address_map  (i_address_map),
      .i_address_char (i_address_char),
      .i_address_item (i_address_item),
      .i_tile_offset  (i_tile_offset),
      .i_char_offset  (i_char_offset),
      .i_hsync        (i_hsync),
      .i_vsync        (i_vsync),
      .i_blank_n      (i_blank_n),
      .i_frame_start  (i_frame_start),
      .i_blink_en     (i_blink_en),
      .o_tile_rom_addr(o_tile_rom_addr),
      .o_char_rom_addr(o_char_rom_addr),
      .o_item_rom_addr(o_item_rom_addr),
      .i_tile_rom_data(tile_data),
      .i_char_rom_data(char_data),
      .i_item_rom_data(item_data),
      .o_r            (o_r),
      .o_g            (o_g),
      .o_b            (o_b),
      .o_hsync        (o_hsync),
      .o_vsync        (o_vsync),
      .o_blank_n      (o_blank_n)
   );

   // ---------------- ROM contents: index = code low nibble + offset low nibble
   function automatic logic [3:0] cell_val(input logic [13:0] a);
      return a[9:6] + a[3:0];
   endfunction

   function automatic logic [3:0] item_val(input logic [7:0] a);
      return a[3:0] + {2'b00, a[7:6]};
   endfunction

   always @(posedge clk) begin
      tile_data <= cell_val(o_tile_rom_addr);
      char_data <= cell_val(o_char_rom_addr);
      item_data <= item_val(o_item_rom_addr);
   end

   // ---------------- reference model
   function automatic logic [26:0] expect_out(input pix_t s, input logic [5:0] cnt,
                                              input logic blink);
      logic [3:0]  tile, chr, itm;
      logic [3:0]  idx;
      logic        vis;
      logic [23:0] rgb;
      tile = s.map[3:0] + s.toff[3:0];
      chr  = s.chr[3:0] + s.coff[3:0];
      itm  = s.toff[3:0] + {2'b00, s.item};
      vis  = !(s.item == 2'd2 && blink && cnt[4]);
      idx  = 4'd0;
      if (s.sel[1] && chr != 4'd0) idx = chr;
      else if (s.sel[0] && (s.item == 2'd1 || s.item == 2'd2) && itm != 4'd0 && vis) idx = itm;
      else if (s.sel[0]) idx = tile;
      rgb = s.bn ? PAL[idx] : 24'h0;
      return {rgb, s.hs, s.vs, s.bn};
   endfunction

   pix_t        pix_q[$];
   pix_t        cur;
   pix_t        old;
   logic [5:0]  m_cnt;
   logic [26:0] exp_out;
   logic [35:0] exp_addr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q.delete();
         pix_q.push_back(RST_PIX);
         pix_q.push_back(RST_PIX);
         m_cnt    = 6'd0;
         exp_out  = {24'h0, 3'b110};
         exp_addr = '0;
      end else begin
         old     = pix_q.pop_front();
         exp_out = expect_out(old, m_cnt, i_blink_en);
         if (i_frame_start) m_cnt = m_cnt + 6'd1;
         cur = '{sel: i_mem_select, map: i_address_map, chr: i_address_char,
                 item: i_address_item, toff: i_tile_offset, coff: i_char_offset,
                 hs: i_hsync, vs: i_vsync, bn: i_blank_n};
         pix_q.push_back(cur);
         exp_addr = {i_address_map, i_tile_offset, i_address_char, i_char_offset,
                     i_address_item, i_tile_offset};
      end
   end

   // ---------------- scoreboard
   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("model_out", 64'({o_r, o_g, o_b, o_hsync, o_vsync, o_blank_n}), 64'(exp_out));
         cmp("model_addr", 64'({o_tile_rom_addr, o_char_rom_addr, o_item_rom_addr}),
             64'(exp_addr));
         cmp("model_cnt", 64'(dut.frame_cnt), 64'(m_cnt));
      end
   end

   // ---------------- driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [1:0] sel, input logic [7:0] map, input logic [7:0] chr,
                          input logic [1:0] item, input logic [5:0] toff,
                          input logic [5:0] coff, input logic bn);
      i_mem_select   = sel;
      i_address_map  = map;
      i_address_char = chr;
      i_address_item = item;
      i_tile_offset  = toff;
      i_char_offset  = coff;
      i_blank_n      = bn;
      i_hsync        = 1'b1;
      i_vsync        = 1'b1;
   endtask

   task automatic pulse_frames(input int n);
      for (int i = 0; i < n; i++) begin
         i_frame_start = 1'b1;
         step(1);
         i_frame_start = 1'b0;
         step(1);
      end
   endtask

   // ---------------- directed sequence
   initial begin
      // reset state, frame_start held high to show it is ignored
      i_frame_start = 1'b1;
      step(3);
      cmp("rst_rgb", 64'({o_r, o_g, o_b}), 64'h0);
      cmp("rst_sync", 64'({o_hsync, o_vsync, o_blank_n}), 64'b110);
      cmp("rst_addr", 64'({o_tile_rom_addr, o_char_rom_addr, o_item_rom_addr}), 64'h0);
      cmp("rst_cnt", 64'(dut.frame_cnt), 64'd0);
      i_frame_start = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      step(1);

      // layer priority: char 5, item 3 (dot), tile 7
      set_pix(2'b11, 8'd5, 8'd5, 2'd1, 6'd2, 6'd0, 1'b1);
      step(3);
      cmp("prio_char", 64'({o_r, o_g, o_b}), 64'h00FFFF);
      i_address_char = 8'd0;
      step(3);
      cmp("prio_item", 64'({o_r, o_g, o_b}), 64'hFFB8AE);
      i_address_item = 2'd0;
      step(3);
      cmp("prio_tile", 64'({o_r, o_g, o_b}), 64'hFFB851);
      i_address_item = 2'd3;
      step(3);
      cmp("prio_reserved", 64'({o_r, o_g, o_b}), 64'hFFB851);
      i_mem_select = 2'b10;
      step(3);
      cmp("sel10_transparent", 64'({o_r, o_g, o_b}), 64'h0);

      // blanking
      set_pix(2'b11, 8'd5, 8'd5, 2'd1, 6'd2, 6'd0, 1'b0);
      step(3);
      cmp("blank_forced", 64'({o_r, o_g, o_b, o_blank_n}), 64'h0);
      set_pix(2'b00, 8'd5, 8'd5, 2'd1, 6'd2, 6'd0, 1'b1);
      step(3);
      cmp("sel00_black", 64'({o_r, o_g, o_b}), 64'h0);

      // alignment: one-cycle hsync low with one-cycle sprite pixel (index 9)
      set_pix(2'b10, 8'd0, 8'd8, 2'd0, 6'd0, 6'd1, 1'b1);
      i_hsync = 1'b0;
      step(1);
      set_pix(2'b00, 8'd0, 8'd0, 2'd0, 6'd0, 6'd0, 1'b1);
      step(2);
      cmp("align_hit", 64'({o_hsync, o_r, o_g, o_b}), {39'h0, 1'b0, 24'h2121FF});
      step(1);
      cmp("align_after", 64'({o_hsync, o_r, o_g, o_b}), {39'h0, 1'b1, 24'h000000});

      // blink: pellet index 4 over tile index 3
      i_blink_en = 1'b1;
      set_pix(2'b01, 8'd1, 8'd0, 2'd2, 6'd2, 6'd0, 1'b1);
      step(3);
      pulse_frames(15);
      cmp("blink_before16", 64'({o_r, o_g, o_b}), 64'hFFB8FF);
      pulse_frames(1);
      step(2);
      cmp("blink_after16", 64'({o_r, o_g, o_b}), 64'hFFB8AE);
      i_blink_en = 1'b0;
      step(3);
      cmp("blink_disabled", 64'({o_r, o_g, o_b}), 64'hFFB8FF);
      i_blink_en = 1'b1;
      pulse_frames(16);
      cmp("blink_cnt32", 64'({o_r, o_g, o_b}), 64'hFFB8FF);
      pulse_frames(16);
      cmp("blink_cnt48", 64'({o_r, o_g, o_b}), 64'hFFB8AE);
      pulse_frames(16);
      step(2);
      cmp("wrap_cnt", 64'(dut.frame_cnt), 64'd0);
      cmp("wrap_visible", 64'({o_r, o_g, o_b}), 64'hFFB8FF);

      // reset mid-stream
      pulse_frames(3);
      set_pix(2'b11, 8'd5, 8'd5, 2'd1, 6'd2, 6'd0, 1'b1);
      step(3);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("midrst_out", 64'({o_r, o_g, o_b, o_hsync, o_vsync, o_blank_n}), 64'b110);
      cmp("midrst_cnt", 64'(dut.frame_cnt), 64'd0);
      i_frame_start = 1'b1;
      step(2);
      cmp("midrst_fs_ignored", 64'(dut.frame_cnt), 64'd0);
      i_frame_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_pix(2'b01, 8'd9, 8'd0, 2'd0, 6'd0, 6'd0, 1'b1);
      step(2);
      cmp("postrst_flushed", 64'({o_r, o_g, o_b, o_blank_n}), 64'h0);
      step(1);
      cmp("postrst_first", 64'({o_r, o_g, o_b, o_blank_n}), {39'h0, 24'h2121FF, 1'b1});

      // mixed vectors checked by the model
      for (int i = 0; i < 60; i++) begin
         i_mem_select   = 2'($urandom_range(0, 3));
         i_address_map  = 8'($urandom_range(0, 255));
         i_address_char = 8'($urandom_range(0, 255));
         i_address_item = 2'($urandom_range(0, 3));
         i_tile_offset  = 6'($urandom_range(0, 63));
         i_char_offset  = 6'($urandom_range(0, 63));
         i_hsync        = 1'($urandom_range(0, 1));
         i_vsync        = 1'($urandom_range(0, 1));
         i_blank_n      = ($urandom_range(0, 3) != 0);
         i_frame_start  = ($urandom_range(0, 2) == 0);
         if (i % 10 == 0) i_blink_en = 1'($urandom_range(0, 1));
         step(1);
      end
      i_frame_start = 1'b0;
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_pixel_compositor.md
# vga_pixel_compositor

Downstream stage of the VGA memory-address generator. It takes the per-pixel memory select, tile/item/character addresses and pixel offsets, and issues reads to the synchronous tile, item and sprite ROMs. It resolves layer priority and transparency, blinks power pellets, maps 4-bit palette indices to 24-bit RGB, and delays the VGA sync/blank signals so they stay aligned with the colour output. Its output drives the VGA DAC pins directly.

## Interface
Parameters:
- `LATENCY`, default 3: pipeline depth from input sample to RGB/sync output. Fixed at 3; exposed only for benches.
- `BLINK_BIT`, default 4: frame-counter bit that gates power-pellet visibility (16 frames on, 16 off).

Ports:
- `i_clk`  in  1  pixel clock. One clock domain.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_select`  in  2  bit1 = character layer valid, bit0 = map/item layer valid.
- `i_address_map`  in  8  tile code.
- `i_address_char`  in  8  sprite part index.
- `i_address_item`  in  2  item code: 0 none, 1 dot, 2 power pellet, 3 reserved (treated as none).
- `i_tile_offset`  in  6  pixel index within the 8x8 tile/item cell.
- `i_char_offset`  in  6  pixel index within the 8x8 sprite part.
- `i_hsync`, `i_vsync`, `i_blank_n`  in  1 each  timing from the VGA controller, same cycle as the addresses.
- `i_frame_start`  in  1  one-cycle pulse per frame.
- `i_blink_en`  in  1  0 = pellets always visible.
- `o_tile_rom_addr`  out  14  {address_map, tile_offset}.
- `o_char_rom_addr`  out  14  {address_char, char_offset}.
- `o_item_rom_addr`  out  8  {address_item, tile_offset}.
- `i_tile_rom_data`, `i_char_rom_data`, `i_item_rom_data`  in  4 each  palette index. ROM read latency is 1 cycle.
- `o_r`, `o_g`, `o_b`  out  8 each  colour.
- `o_hsync`, `o_vsync`, `o_blank_n`  out  1 each  delayed timing.

## Operation
- **S0 (edge k):** register the three ROM addresses. Register the select bits, the item code and the sync signals into the stage-0 sideband.
- **S1 (edge k+1):** ROM data becomes valid. Advance the sideband.
- **S2 (edge k+2):** compose and apply the palette, then register the outputs.
- **Priority:**
  - Use the character pixel if sel[1]=1 and char index is nonzero (index 0 is transparent).
  - Otherwise use the item pixel if sel[0]=1, the item code is 1 or 2, the item index is nonzero, and the pellet is visible.
  - Otherwise use the tile pixel if sel[0]=1.
  - Otherwise output index 0.
- **Pellet visible:** item code is not 2, or `i_blink_en`=0, or `frame_cnt[BLINK_BIT]`=0.
- **Frame counter:** 6 bits. Increments by 1 on each cycle where `i_frame_start`=1. Wraps from 63 to 0.
- **Blink sampling:** visibility is evaluated from the counter value at S2. A frame_start pulse takes effect on the pixel sampled at S2 in the following cycle.
- **Palette:** 16-entry constant LUT. Index 0 is black (0,0,0).
- **Blanking:** when the delayed `blank_n`=0, RGB is forced to 0 regardless of layers.

## Timing
- The S2 output after edge k+2 reflects inputs sampled at edge k. Throughput is one pixel per cycle with no stalls.
- Syncs are delayed by exactly 3 registers, the same depth as RGB.
- Reset values, applied asynchronously:
  - `o_r`, `o_g`, `o_b` = 0.
  - `o_hsync` = `o_vsync` = 1 (inactive).
  - `o_blank_n` = 0.
  - ROM addresses = 0.
  - All sideband registers cleared to these values.
  - `frame_cnt` = 0.
- Reset mid-frame: the pipeline flushes immediately. The first valid output appears 3 cycles after the first post-reset sample.
- `i_frame_start` during reset is ignored.
- `i_mem_select`=2'b10 with a transparent char pixel gives black, not the tile.

## Structure
- Shared package `pacman_video_pkg`:
  - item code constants `ITEM_NONE`, `ITEM_DOT`, `ITEM_PELLET`;
  - `TRANSPARENT_IDX` = 0;
  - `PALETTE[16]` of 24-bit RGB;
  - a `rgb_t` struct.
- Sub-module `sync_delay_line`: parameterised width and depth, used for the hsync/vsync/blank/select/item sideband.

## Test plan
- **Layer priority:** sel=11, char index 5, item 3, tile 7 → after 3 cycles RGB = PALETTE[5]. Then char index 0 → PALETTE[item index 3] with code 1, or PALETTE[7] with code 0.
- **Blink:** item code 2, item idx 4, `i_blink_en`=1, pulse `i_frame_start` 16 times → PALETTE[4] before the 16th pulse, tile colour after. With `i_blink_en`=0 the output is PALETTE[4] throughout.
- **Alignment:** drive a single-cycle hsync low and a single-cycle char pixel at the same edge → both appear on the same output cycle, exactly 3 cycles later.
- **Blanking:** `blank_n`=0 with sel=11 and nonzero data → RGB = 0. sel=00 with `blank_n`=1 → RGB = 0.
- **Reset mid-stream:** assert `i_rst_n` low asynchronously mid-pixel → outputs are 0/1/1/0 within the same cycle and `frame_cnt` = 0. After release, 3 cycles later the output matches the first sampled pixel.
- **Frame counter wrap:** 64 `i_frame_start` pulses → `frame_cnt` returns to 0. Pellet visibility follows bit 4 across the wrap.
